// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, waits for a debounced lock with
// timeout and retry, then releases the per-domain resets in a staggered order.
// Any loss of lock after release re-runs the whole sequence.
// Optional feature macro: PLL_SEQ_RETRY_EN enables the retry limit and the
// FAULT state. Without it the block retries forever and fault stays 0.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned N_DOM        = 6,
  parameter int unsigned STAGGER      = 8,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic [N_DOM-1:0] dom_rst,
  output logic             ready,
  output logic             fault,
  output logic [3:0]       retry_cnt,
  output logic [2:0]       state
);

  // Largest count any state needs; one shared counter serves every state.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned REL_LAST = (N_DOM - 1) * STAGGER;
  localparam int unsigned CNT_SPAN = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                          max2(LOCK_STABLE, REL_LAST + 1));
  localparam int unsigned CNT_W    = $clog2(CNT_SPAN + 1);
  localparam int unsigned RETRY_W  = 4;

`ifdef PLL_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [RETRY_W-1:0] retry_inc;
  logic               retry_exhausted;
  logic [1:0]         sync_q;
  logic               lock_s;
  logic               pll_rst_q, pll_rst_d;
  logic [N_DOM-1:0]   dom_rst_q, dom_rst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign lock_s = sync_q[1];

  // Saturating failed-attempt count and retry-limit test.
  assign retry_inc       = (retry_q == {RETRY_W{1'b1}}) ? retry_q : retry_q + RETRY_W'(1);
  assign retry_exhausted = RETRY_EN && ((32'(retry_q) + 32'd1) == MAX_RETRY);

  // State, counter and output registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_rst_q <= '1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      dom_rst_q <= dom_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state, counter and retry logic; enable=0 overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        retry_d = '0;
        if (enable) begin
          state_d = ST_PLL_RST;
        end
      end

      ST_PLL_RST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      ST_WAIT_LOCK: begin
        // Lock wins over a timeout expiring on the same cycle.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = retry_exhausted ? ST_FAULT : ST_PLL_RST;
        end
      end

      ST_STABLE: begin
        // A single low cycle restarts the lock wait without counting a retry.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(REL_LAST)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        cnt_d   = '0;
        retry_d = '0;
        if (!lock_s) begin
          state_d = ST_PLL_RST;
        end
      end

      ST_FAULT: begin
        cnt_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // Registered outputs decoded from the next state and next count.
  always_comb begin
    pll_rst_d = 1'b0;
    dom_rst_d = '1;
    ready_d   = 1'b0;
    fault_d   = 1'b0;

    unique case (state_d)
      ST_IDLE, ST_PLL_RST: begin
        pll_rst_d = 1'b1;
      end
      ST_RELEASE: begin
        // Domain i is released once the count reaches i*STAGGER.
        for (int unsigned i = 0; i < N_DOM; i++) begin
          dom_rst_d[i] = (32'(cnt_d) < (i * STAGGER));
        end
      end
      ST_RUN: begin
        dom_rst_d = '0;
        ready_d   = 1'b1;
      end
      ST_FAULT: begin
        pll_rst_d = 1'b1;
`ifdef PLL_SEQ_RETRY_EN
        fault_d   = 1'b1;
`else
        fault_d   = 1'b0;
`endif
      end
      default: begin
        pll_rst_d = 1'b0;
      end
    endcase
  end

  assign pll_rst   = pll_rst_q;
  assign dom_rst   = dom_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus pushes every expected
// output change with the refclk edge it must land on; a monitor pops and
// compares whenever the observable outputs change.
module tb_pll_reset_sequencer;

  localparam int unsigned N_DOM = 6;

  logic             refclk;
  logic             rst_n;
  logic             enable;
  logic             pll_locked;
  logic             pll_rst;
  logic [N_DOM-1:0] dom_rst;
  logic             ready;
  logic             fault;
  logic [3:0]       retry_cnt;
  logic [2:0]       state;

  typedef struct {
    int          cyc;
    logic [15:0] snap;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;
  bit   done   = 1'b0;

  pll_reset_sequencer dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .dom_rst    (dom_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  always @(posedge refclk) cyc <= cyc + 1;

  function automatic logic [15:0] snap(input logic [2:0] st, input logic pr,
                                       input logic [5:0] dm, input logic rd,
                                       input logic ft, input int rt);
    return {st, pr, dm, rd, ft, 4'(rt)};
  endfunction

  task automatic push(input int c, input logic [15:0] s);
    exp_t e;
    e.cyc  = c;
    e.snap = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge refclk);
  endtask

  // Staggered release starting at edge base, then RUN with ready=1.
  task automatic push_release(input int base);
    logic [5:0] all_ones;
    all_ones = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      push(base + 8 * i, snap(3'd4, 1'b0, 6'(all_ones << (i + 1)), 1'b0, 1'b0, 0));
    end
    push(base + 41, snap(3'd5, 1'b0, 6'h00, 1'b1, 1'b0, 0));
  endtask

  // Monitor: compares each output change against the next expected event.
  initial begin : monitor
    logic [15:0] cur;
    logic [15:0] prev;
    bit          have_prev;
    exp_t        e;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge refclk or negedge rst_n);
      #1;
      if (done) break;
      cur = {state, pll_rst, dom_rst, ready, fault, retry_cnt};
      if (!have_prev || cur != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change: got outputs=%h at cycle %0d, required no change from %h",
                   cur, cyc, prev);
        end else begin
          e = exp_q.pop_front();
          if (cur == e.snap && (e.cyc < 0 || e.cyc == cyc)) begin
            passes++;
          end else begin
            $display("FAIL output_change: got outputs=%h at cycle %0d, required %h at cycle %0d",
                     cur, cyc, e.snap, e.cyc);
          end
        end
        prev      = cur;
        have_prev = 1'b1;
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL queue_drain: got %0d expected changes never seen, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Stimulus.
  initial begin : stimulus
    int e;
    int r;
    int a;
    int b;
    int t;
    rst_n      = 1'b1;
    enable     = 1'b0;
    pll_locked = 1'b0;
    push(-1, snap(3'd0, 1'b1, 6'h3F, 1'b0, 1'b0, 0));
    #1 rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;

    // Clean bring-up, lock rising 40 cycles after enable.
    e = cyc;
    enable = 1'b1;
    push(e + 1,  snap(3'd1, 1'b1, 6'h3F, 1'b0, 1'b0, 0));
    push(e + 17, snap(3'd2, 1'b0, 6'h3F, 1'b0, 1'b0, 0));
    push(e + 43, snap(3'd3, 1'b0, 6'h3F, 1'b0, 1'b0, 0));
    push_release(e + 299);
    wait_cyc(e + 40);
    pll_locked = 1'b1;
    wait_cyc(e + 345);

    // Lock loss in RUN, relock, then a one-cycle glitch 100 cycles into STABLE.
    r = cyc;
    pll_locked = 1'b0;
    push(r + 3,   snap(3'd1, 1'b1, 6'h3F, 1'b0, 1'b0, 0));
    push(r + 19,  snap(3'd2, 1'b0, 6'h3F, 1'b0, 1'b0, 0));
    push(r + 23,  snap(3'd3, 1'b0, 6'h3F, 1'b0, 1'b0, 0));
    push(r + 126, snap(3'd2, 1'b0, 6'h3F, 1'b0, 1'b0, 0));
    push(r + 127, snap(3'd3, 1'b0, 6'h3F, 1'b0, 1'b0, 0));
    push_release(r + 383);
    wait_cyc(r + 20);
    pll_locked = 1'b1;
    wait_cyc(r + 123);
    pll_locked = 1'b0;
    wait_cyc(r + 124);
    pll_locked = 1'b1;
    wait_cyc(r + 430);

    // Enable drop to IDLE, restart, async reset with three domains released.
    a = cyc;
    enable = 1'b0;
    push(a + 1,   snap(3'd0, 1'b1, 6'h3F, 1'b0, 1'b0, 0));
    push(a + 3,   snap(3'd1, 1'b1, 6'h3F, 1'b0, 1'b0, 0));
    push(a + 19,  snap(3'd2, 1'b0, 6'h3F, 1'b0, 1'b0, 0));
    push(a + 20,  snap(3'd3, 1'b0, 6'h3F, 1'b0, 1'b0, 0));
    push(a + 276, snap(3'd4, 1'b0, 6'h3E, 1'b0, 1'b0, 0));
    push(a + 284, snap(3'd4, 1'b0, 6'h3C, 1'b0, 1'b0, 0));
    push(a + 292, snap(3'd4, 1'b0, 6'h38, 1'b0, 1'b0, 0));
    wait_cyc(a + 2);
    enable = 1'b1;
    wait_cyc(a + 294);
    #2;
    push(a + 294, snap(3'd0, 1'b1, 6'h3F, 1'b0, 1'b0, 0));
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    enable     = 1'b0;
    wait_cyc(a + 297);
    rst_n = 1'b1;

    // Lock never arrives: repeated timeouts.
    b = cyc;
    enable = 1'b1;
    push(b + 1,  snap(3'd1, 1'b1, 6'h3F, 1'b0, 1'b0, 0));
    push(b + 17, snap(3'd2, 1'b0, 6'h3F, 1'b0, 1'b0, 0));
`ifdef PLL_SEQ_RETRY_EN
    for (int n = 1; n <= 2; n++) begin
      t = b + 4113 + (n - 1) * 4112;
      push(t,      snap(3'd1, 1'b1, 6'h3F, 1'b0, 1'b0, n));
      push(t + 16, snap(3'd2, 1'b0, 6'h3F, 1'b0, 1'b0, n));
    end
    push(b + 12337, snap(3'd6, 1'b1, 6'h3F, 1'b0, 1'b1, 3));
    wait_cyc(b + 12340);
`else
    for (int n = 1; n <= 10; n++) begin
      t = b + 4113 + (n - 1) * 4112;
      push(t,      snap(3'd1, 1'b1, 6'h3F, 1'b0, 1'b0, n));
      push(t + 16, snap(3'd2, 1'b0, 6'h3F, 1'b0, 1'b0, n));
    end
    wait_cyc(b + 4129 + 9 * 4112 + 10);
`endif
    t = cyc;
    enable = 1'b0;
    push(t + 1, snap(3'd0, 1'b1, 6'h3F, 1'b0, 1'b0, 0));
    wait_cyc(t + 5);
    done = 1'b1;
  end

endmodule
